shift_pipe: RTL

- Two-stage pipelined barrel shifter for the ALU shift path: SLL and SRA of a 32-bit operand by a 5-bit amount, built from fixed-distance shift stages (16/8 in stage 1; 4/2/1 in stage 2).
- Sits between the decode/operand-select logic and writeback.
- Valid/ready handshake on both sides, full throughput of one operation per cycle.
- Exception flag for unsupported opcodes.

---
 rtl/shift_pipe_if.sv | 26 ++
 rtl/shift_pipe.sv | 132 +++++++++++++
 2 files changed

// File: rtl/shift_pipe_if.sv
// Handshake and data bundle between operand select, the shift pipe and writeback.
// The master drives operations in and consumes results; the slave is the shifter.
interface shift_pipe_if #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_BITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      data_operandA;
  logic [SHAMT_BITS-1:0] ctrl_shiftamt;
  logic [4:0]            ctrl_ALUopcode;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      data_result;
  logic                  data_exception;

  modport master (
    output in_valid, data_operandA, ctrl_shiftamt, ctrl_ALUopcode, out_ready,
    input  in_ready, out_valid, data_result, data_exception
  );

  modport slave (
    input  in_valid, data_operandA, ctrl_shiftamt, ctrl_ALUopcode, out_ready,
    output in_ready, out_valid, data_result, data_exception
  );
endinterface

// File: rtl/shift_pipe.sv
// Two-stage SLL/SRA barrel shifter (16/8 in stage 1, 4/2/1 in stage 2) with valid/ready.
// Define SHIFT_PIPE_SRL_EN to add opcode 00110 as a logical right shift.
module shift_pipe #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_BITS = 5
) (
  input  logic         clock,
  input  logic         reset,
  shift_pipe_if.slave  bus
);

  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
`ifdef SHIFT_PIPE_SRL_EN
  localparam logic [4:0] OP_SRL = 5'b00110;
`endif

  logic                  s1_valid;
  logic [WIDTH-1:0]      s1_data;
  logic [SHAMT_BITS-3:0] s1_shamt;
  logic                  s1_left;
  logic                  s1_arith;
  logic                  s1_exc;

  logic                  s2_valid;
  logic [WIDTH-1:0]      s2_result;
  logic                  s2_exc;

  logic s2_adv;
  logic in_fire;
  logic s1_move;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign s1_move      = s1_valid && s2_adv;

  assign bus.out_valid      = s2_valid;
  assign bus.data_result    = s2_result;
  assign bus.data_exception = s2_exc;

  logic dec_left;
  logic dec_arith;
  logic dec_exc;

  // Opcode decode: left vs right direction, arithmetic vs zero fill, or unsupported.
  always_comb begin
    dec_left  = 1'b0;
    dec_arith = 1'b0;
    dec_exc   = 1'b0;
    case (bus.ctrl_ALUopcode)
      OP_SLL: dec_left = 1'b1;
      OP_SRA: dec_arith = 1'b1;
`ifdef SHIFT_PIPE_SRL_EN
      OP_SRL: dec_arith = 1'b0;
`endif
      default: dec_exc = 1'b1;
    endcase
  end

  logic             s1_fill;
  logic [WIDTH-1:0] p16;
  logic [WIDTH-1:0] p8;

  assign s1_fill = dec_arith & bus.data_operandA[WIDTH-1];

  always_comb begin
    p16 = bus.data_operandA;
    if (bus.ctrl_shiftamt[4])
      p16 = dec_left ? {bus.data_operandA[15:0], 16'b0}
                     : {{16{s1_fill}}, bus.data_operandA[31:16]};
    p8 = p16;
    if (bus.ctrl_shiftamt[3])
      p8 = dec_left ? {p16[23:0], 8'b0} : {{8{s1_fill}}, p16[31:8]};
  end

  // The partial keeps bit 31 as the sign for SRA, so stage 2 can refill from it.
  logic             s2_fill;
  logic [WIDTH-1:0] p4;
  logic [WIDTH-1:0] p2;
  logic [WIDTH-1:0] p1;

  assign s2_fill = s1_arith & s1_data[WIDTH-1];

  always_comb begin
    p4 = s1_data;
    if (s1_shamt[2])
      p4 = s1_left ? {s1_data[27:0], 4'b0} : {{4{s2_fill}}, s1_data[31:4]};
    p2 = p4;
    if (s1_shamt[1])
      p2 = s1_left ? {p4[29:0], 2'b0} : {{2{s2_fill}}, p4[31:2]};
    p1 = p2;
    if (s1_shamt[0])
      p1 = s1_left ? {p2[30:0], 1'b0} : {s2_fill, p2[31:1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_left  <= 1'b0;
      s1_arith <= 1'b0;
      s1_exc   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= p8;
      s1_shamt <= bus.ctrl_shiftamt[2:0];
      s1_left  <= dec_left;
      s1_arith <= dec_arith;
      s1_exc   <= dec_exc;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 holds its result while the consumer stalls; unsupported ops yield zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_exc    <= 1'b0;
    end else if (s1_move) begin
      s2_valid  <= 1'b1;
      s2_result <= s1_exc ? '0 : p1;
      s2_exc    <= s1_exc;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule
